// File: rtl/oflow_score_calc_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : oflow_score_calc_multi_pkg
//  Purpose  : Shared types and helpers for the multi-lane score calculator.
//             Provides the controller state encoding, the empty-score / empty-ID
//             sentinels and a helper that extracts one lane field from a
//             flattened per-lane vector.
//  Revision : 1.0  initial release
// ============================================================================
package oflow_score_calc_multi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ROW = 3'd1,
    COLLECT  = 3'd2,
    UPDATE   = 3'd3,
    REDUCE   = 3'd4,
    DONE     = 3'd5
  } state_e;

  // Sentinels are kept at the widest supported field width; users slice them
  // down to SCORE_LEN / ID_LEN.
  localparam logic [31:0] SCORE_MAX = 32'hFFFF_FFFF;
  localparam logic [31:0] NO_ID     = 32'h0000_0000;

  localparam int unsigned MAX_LANES = 8;
  localparam int unsigned MAX_FIELD = 32;
  localparam int unsigned VEC_W     = MAX_LANES * MAX_FIELD;

  // Returns field number 'lane' (each 'width' bits wide) of a flattened
  // vector, zero-extended to 32 bits. Callers widen their vector to VEC_W.
  function automatic logic [31:0] lane_slice(input logic [VEC_W-1:0] vec,
                                             input int unsigned      lane,
                                             input int unsigned      width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return 32'(vec >> (lane * width)) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oflow_lane_min_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : oflow_lane_min_tracker
//  Purpose  : One similarity-metric lane. Captures the first result of a row,
//             flags it as received, and on update folds it into the running
//             minimum when it passes the threshold and is strictly smaller.
//  Ports    : clk, reset_N        clock / async active-low reset
//             clear               start of search: min to all ones, id to 0
//             capture             lane result valid for an active lane
//             res_score, res_id   lane result
//             update              end of row: fold capture into minimum
//             threshold           acceptance threshold (score <= threshold)
//             got                 result for the current row captured
//             min_score, min_id   running minimum and its ID (0 = none)
//  Revision : 1.0  initial release
// ============================================================================
module oflow_lane_min_tracker
  import oflow_score_calc_multi_pkg::*;
#(
  parameter int SCORE_LEN = 16,
  parameter int ID_LEN    = 12
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 clear,
  input  logic                 capture,
  input  logic [SCORE_LEN-1:0] res_score,
  input  logic [ID_LEN-1:0]    res_id,
  input  logic                 update,
  input  logic [SCORE_LEN-1:0] threshold,
  output logic                 got,
  output logic [SCORE_LEN-1:0] min_score,
  output logic [ID_LEN-1:0]    min_id
);

  localparam logic [SCORE_LEN-1:0] SCORE_EMPTY = SCORE_MAX[SCORE_LEN-1:0];
  localparam logic [ID_LEN-1:0]    ID_EMPTY    = NO_ID[ID_LEN-1:0];

  logic                 got_q,       got_d;
  logic [SCORE_LEN-1:0] cap_score_q, cap_score_d;
  logic [ID_LEN-1:0]    cap_id_q,    cap_id_d;
  logic [SCORE_LEN-1:0] min_score_q, min_score_d;
  logic [ID_LEN-1:0]    min_id_q,    min_id_d;

  always_comb begin
    got_d       = got_q;
    cap_score_d = cap_score_q;
    cap_id_d    = cap_id_q;
    min_score_d = min_score_q;
    min_id_d    = min_id_q;

    if (clear) begin
      got_d       = 1'b0;
      min_score_d = SCORE_EMPTY;
      min_id_d    = ID_EMPTY;
    end else if (update) begin
      // Strict '<' keeps the earlier row on equal scores; an all-ones score
      // can never beat the empty sentinel.
      if (got_q && (cap_score_q <= threshold) && (cap_score_q < min_score_q)) begin
        min_score_d = cap_score_q;
        min_id_d    = cap_id_q;
      end
      got_d = 1'b0;
    end else if (capture && !got_q) begin
      // Only the first result of a row is kept.
      got_d       = 1'b1;
      cap_score_d = res_score;
      cap_id_d    = res_id;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      got_q       <= 1'b0;
      cap_score_q <= '0;
      cap_id_q    <= '0;
      min_score_q <= SCORE_EMPTY;
      min_id_q    <= ID_EMPTY;
    end else begin
      got_q       <= got_d;
      cap_score_q <= cap_score_d;
      cap_id_q    <= cap_id_d;
      min_score_q <= min_score_d;
      min_id_q    <= min_id_d;
    end
  end

  assign got       = got_q;
  assign min_score = min_score_q;
  assign min_id    = min_id_q;

endmodule
`default_nettype wire

// File: rtl/oflow_score_calc_multi.sv
`default_nettype none
// ============================================================================
//  Module   : oflow_score_calc_multi
//  Purpose  : Sequences NUM_LANES similarity-metric lanes over the previous-
//             frame buffer one row at a time, tracks a per-lane minimum score
//             and ID, then reduces the lanes to a single global best match.
//  Ports    : clk, reset_N                   clock / async active-low reset
//             start_score_calc, busy,
//             done_score_calc                search control
//             score_threshold                acceptance threshold
//             row_valid/ready/last, row_ids  buffer row handshake
//             sm_start, sm_valid, sm_score,
//             sm_id                          per-lane metric interface
//             min_score, min_id              per-lane minima
//             global_min_score/id            global best match
//  Revision : 1.0  initial release
// ============================================================================
module oflow_score_calc_multi
  import oflow_score_calc_multi_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int SCORE_LEN = 16,
  parameter int ID_LEN    = 12
) (
  input  logic                           clk,
  input  logic                           reset_N,
  input  logic                           start_score_calc,
  input  logic [SCORE_LEN-1:0]           score_threshold,
  input  logic                           row_valid,
  output logic                           row_ready,
  input  logic                           row_last,
  input  logic [NUM_LANES*ID_LEN-1:0]    row_ids,
  output logic [NUM_LANES-1:0]           sm_start,
  input  logic [NUM_LANES-1:0]           sm_valid,
  input  logic [NUM_LANES*SCORE_LEN-1:0] sm_score,
  input  logic [NUM_LANES*ID_LEN-1:0]    sm_id,
  output logic [NUM_LANES*SCORE_LEN-1:0] min_score,
  output logic [NUM_LANES*ID_LEN-1:0]    min_id,
  output logic [SCORE_LEN-1:0]           global_min_score,
  output logic [ID_LEN-1:0]              global_min_id,
  output logic                           busy,
  output logic                           done_score_calc
);

  localparam logic [SCORE_LEN-1:0] SCORE_EMPTY = SCORE_MAX[SCORE_LEN-1:0];
  localparam logic [ID_LEN-1:0]    ID_EMPTY    = NO_ID[ID_LEN-1:0];
  localparam logic [2:0]           LAST_LANE   = 3'(NUM_LANES - 1);

  state_e                 state_q,       state_d;
  logic [NUM_LANES-1:0]   active_mask_q, active_mask_d;
  logic                   last_q,        last_d;
  logic [NUM_LANES-1:0]   sm_start_q,    sm_start_d;
  logic [2:0]             lane_idx_q,    lane_idx_d;
  logic [SCORE_LEN-1:0]   gmin_score_q,  gmin_score_d;
  logic [ID_LEN-1:0]      gmin_id_q,     gmin_id_d;

  logic                   clear_lanes;
  logic                   update_lanes;
  logic [NUM_LANES-1:0]   row_active;
  logic [NUM_LANES-1:0]   got_vec;
  logic [NUM_LANES-1:0]   capture_vec;
  logic [SCORE_LEN-1:0]   red_score;
  logic [ID_LEN-1:0]      red_id;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign row_active[k]  = (row_ids[k*ID_LEN +: ID_LEN] != ID_EMPTY);
    // Results on lanes not started for this row, or outside COLLECT, are dropped.
    assign capture_vec[k] = (state_q == COLLECT) && sm_valid[k] && active_mask_q[k];

    oflow_lane_min_tracker #(
      .SCORE_LEN (SCORE_LEN),
      .ID_LEN    (ID_LEN)
    ) u_tracker (
      .clk       (clk),
      .reset_N   (reset_N),
      .clear     (clear_lanes),
      .capture   (capture_vec[k]),
      .res_score (sm_score[k*SCORE_LEN +: SCORE_LEN]),
      .res_id    (sm_id[k*ID_LEN +: ID_LEN]),
      .update    (update_lanes),
      .threshold (score_threshold),
      .got       (got_vec[k]),
      .min_score (min_score[k*SCORE_LEN +: SCORE_LEN]),
      .min_id    (min_id[k*ID_LEN +: ID_LEN])
    );
  end

  // Lane currently visited by the reduction scan.
  assign red_score = SCORE_LEN'(lane_slice(VEC_W'(min_score), 32'(lane_idx_q), SCORE_LEN));
  assign red_id    = ID_LEN'(lane_slice(VEC_W'(min_id), 32'(lane_idx_q), ID_LEN));

  always_comb begin
    state_d       = state_q;
    active_mask_d = active_mask_q;
    last_d        = last_q;
    sm_start_d    = '0;
    lane_idx_d    = lane_idx_q;
    gmin_score_d  = gmin_score_q;
    gmin_id_d     = gmin_id_q;
    clear_lanes   = 1'b0;
    update_lanes  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_score_calc) begin
          clear_lanes  = 1'b1;
          gmin_score_d = SCORE_EMPTY;
          gmin_id_d    = ID_EMPTY;
          state_d      = WAIT_ROW;
        end
      end
      WAIT_ROW: begin
        if (row_valid) begin
          active_mask_d = row_active;
          last_d        = row_last;
          if (row_active != '0) begin
            // Registered so the start pulse appears in the first COLLECT cycle.
            sm_start_d = row_active;
            state_d    = COLLECT;
          end else begin
            state_d = UPDATE;
          end
        end
      end
      COLLECT: begin
        // Include this cycle's valids so the last one moves on without a bubble.
        if ((got_vec | (sm_valid & active_mask_q)) == active_mask_q) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        update_lanes = 1'b1;
        lane_idx_d   = '0;
        state_d      = last_q ? REDUCE : WAIT_ROW;
      end
      REDUCE: begin
        // Strict '<' during an ascending scan: lowest lane index wins ties.
        if ((red_id != ID_EMPTY) && (red_score < gmin_score_q)) begin
          gmin_score_d = red_score;
          gmin_id_d    = red_id;
        end
        if (lane_idx_q == LAST_LANE) begin
          state_d = DONE;
        end else begin
          lane_idx_d = lane_idx_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q       <= IDLE;
      active_mask_q <= '0;
      last_q        <= 1'b0;
      sm_start_q    <= '0;
      lane_idx_q    <= '0;
      gmin_score_q  <= SCORE_EMPTY;
      gmin_id_q     <= ID_EMPTY;
    end else begin
      state_q       <= state_d;
      active_mask_q <= active_mask_d;
      last_q        <= last_d;
      sm_start_q    <= sm_start_d;
      lane_idx_q    <= lane_idx_d;
      gmin_score_q  <= gmin_score_d;
      gmin_id_q     <= gmin_id_d;
    end
  end

  assign row_ready        = (state_q == WAIT_ROW);
  assign sm_start         = sm_start_q;
  assign busy             = (state_q != IDLE) && (state_q != DONE);
  assign done_score_calc  = (state_q == DONE);
  assign global_min_score = gmin_score_q;
  assign global_min_id    = gmin_id_q;

endmodule
`default_nettype wire

// File: tb/tb_oflow_score_calc_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oflow_score_calc_multi
//  Purpose  : Directed self-checking bench. A 2-lane and a 4-lane instance
//             share the row and lane-result buses; each has its own start.
//  Revision : 1.0  initial release
// ============================================================================
module tb_oflow_score_calc_multi;

  logic        clk = 1'b0;
  logic        reset_N;
  logic [15:0] thr;
  logic        row_valid, row_last;
  logic [47:0] row_ids;
  logic [3:0]  sm_valid;
  logic [63:0] sm_score;
  logic [47:0] sm_id;

  logic        start2, row_ready2, busy2, done2;
  logic [1:0]  sm_start2;
  logic [31:0] min_score2;
  logic [23:0] min_id2;
  logic [15:0] gms2;
  logic [11:0] gmi2;

  logic        start4, row_ready4, busy4, done4;
  logic [3:0]  sm_start4;
  logic [63:0] min_score4;
  logic [47:0] min_id4;
  logic [15:0] gms4;
  logic [11:0] gmi4;

  int checks = 0;
  int errors = 0;
  int edges;

  always #5 clk = ~clk;

  oflow_score_calc_multi #(.NUM_LANES(2), .SCORE_LEN(16), .ID_LEN(12)) u_dut2 (
    .clk(clk), .reset_N(reset_N), .start_score_calc(start2), .score_threshold(thr),
    .row_valid(row_valid), .row_ready(row_ready2), .row_last(row_last),
    .row_ids(row_ids[23:0]), .sm_start(sm_start2), .sm_valid(sm_valid[1:0]),
    .sm_score(sm_score[31:0]), .sm_id(sm_id[23:0]), .min_score(min_score2),
    .min_id(min_id2), .global_min_score(gms2), .global_min_id(gmi2),
    .busy(busy2), .done_score_calc(done2));

  oflow_score_calc_multi #(.NUM_LANES(4), .SCORE_LEN(16), .ID_LEN(12)) u_dut4 (
    .clk(clk), .reset_N(reset_N), .start_score_calc(start4), .score_threshold(thr),
    .row_valid(row_valid), .row_ready(row_ready4), .row_last(row_last),
    .row_ids(row_ids), .sm_start(sm_start4), .sm_valid(sm_valid),
    .sm_score(sm_score), .sm_id(sm_id), .min_score(min_score4),
    .min_id(min_id4), .global_min_score(gms4), .global_min_id(gmi4),
    .busy(busy4), .done_score_calc(done4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 2) ? row_ready2 : row_ready4;
  endfunction

  function automatic logic dn(input int d);
    return (d == 2) ? done2 : done4;
  endfunction

  function automatic logic bz(input int d);
    return (d == 2) ? busy2 : busy4;
  endfunction

  function automatic logic [3:0] sms(input int d);
    return (d == 2) ? {2'b00, sm_start2} : sm_start4;
  endfunction

  // Called #1 after a posedge; returns #1 after the posedge that accepted it.
  task automatic start_search(input int d);
    if (d == 2) start2 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; start4 = 1'b0;
    chk("busy_after_start", {63'd0, bz(d)}, 64'd1);
  endtask

  // Presents one row, then pulses sm_valid per lane in the cycle given by
  // dlyN (1 = the cycle sm_start is high, 0 = never). Lanes whose row id is 0
  // still receive id 99 on sm_id so injected results are recognisable.
  task automatic run_row(input int d, input logic [47:0] ids, input logic last,
                         input logic [63:0] scores, input int dl0, input int dl1,
                         input int dl2, input int dl3, input logic [3:0] exp_start);
    int n;
    int maxd;
    logic [11:0] lid;
    row_ids   = ids;
    row_last  = last;
    row_valid = 1'b1;
    sm_score  = scores;
    for (int k = 0; k < 4; k++) begin
      lid = ids[k*12 +: 12];
      sm_id[k*12 +: 12] = (lid == 12'd0) ? 12'd99 : lid;
    end
    n = 0;
    while (!rdy(d) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("row_ready_wait", {63'd0, rdy(d)}, 64'd1);
    @(posedge clk); #1;
    row_valid = 1'b0;
    row_last  = 1'b0;
    chk("sm_start", {60'd0, sms(d)}, {60'd0, exp_start});
    maxd = dl0;
    if (dl1 > maxd) maxd = dl1;
    if (dl2 > maxd) maxd = dl2;
    if (dl3 > maxd) maxd = dl3;
    for (int c = 1; c <= maxd; c++) begin
      sm_valid = {(dl3 == c), (dl2 == c), (dl1 == c), (dl0 == c)};
      @(posedge clk); #1;
    end
    sm_valid = 4'd0;
  endtask

  // Counts posedges until done is seen, then checks it is a single pulse.
  task automatic wait_done(input int d, output int e);
    e = 0;
    while (!dn(d) && e < 200) begin
      @(posedge clk); #1;
      e++;
    end
    chk("done_seen", {63'd0, dn(d)}, 64'd1);
    chk("busy_at_done", {63'd0, bz(d)}, 64'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {63'd0, dn(d)}, 64'd0);
  endtask

  initial begin
    reset_N = 1'b0; thr = 16'hFFFE; row_valid = 1'b0; row_last = 1'b0;
    row_ids = '0; sm_valid = '0; sm_score = '0; sm_id = '0;
    start2 = 1'b0; start4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row_ready", {63'd0, row_ready2}, 64'd0);
    chk("rst_busy", {62'd0, busy4, busy2}, 64'd0);
    chk("rst_done", {62'd0, done4, done2}, 64'd0);
    chk("rst_sm_start", {58'd0, sm_start4, sm_start2}, 64'd0);
    chk("rst_min_score2", {32'd0, min_score2}, {32'd0, 32'hFFFF_FFFF});
    chk("rst_min_id4", {16'd0, min_id4}, 64'd0);
    chk("rst_global", {36'd0, gms2, gmi2}, {36'd0, 16'hFFFF, 12'd0});
    @(negedge clk); reset_N = 1'b1;
    @(posedge clk); #1;

    // Three rows, tie on lane 0 keeps row 2.
    start_search(2);
    chk("row_ready_wait_row", {63'd0, row_ready2}, 64'd1);
    run_row(2, {24'd0, 12'd8, 12'd5}, 1'b0, {32'd0, 16'd30, 16'd40}, 1, 1, 0, 0, 4'b0011);
    run_row(2, {24'd0, 12'd9, 12'd6}, 1'b0, {32'd0, 16'd50, 16'd25}, 1, 2, 0, 0, 4'b0011);
    run_row(2, {24'd0, 12'd10, 12'd7}, 1'b1, {32'd0, 16'd10, 16'd25}, 1, 1, 0, 0, 4'b0011);
    wait_done(2, edges);
    // Last valid cycle -> UPDATE, 2 REDUCE, DONE: three edges after it registers.
    chk("latency_t1", 64'(edges), 64'd3);
    chk("t1_min_score", {32'd0, min_score2}, {32'd0, 16'd10, 16'd25});
    chk("t1_min_id", {40'd0, min_id2}, {40'd0, 12'd10, 12'd6});
    chk("t1_global", {36'd0, gms2, gmi2}, {36'd0, 16'd10, 12'd10});

    // Lane 1 empty: only lane 0 starts; an injected lane-1 valid is dropped.
    start_search(2);
    run_row(2, {24'd0, 12'd0, 12'd11}, 1'b1, {32'd0, 16'd1, 16'd7}, 1, 1, 0, 0, 4'b0001);
    wait_done(2, edges);
    chk("t2_min_score", {32'd0, min_score2}, {32'd0, 16'hFFFF, 16'd7});
    chk("t2_min_id", {40'd0, min_id2}, {40'd0, 12'd0, 12'd11});
    chk("t2_global", {36'd0, gms2, gmi2}, {36'd0, 16'd7, 12'd11});

    // Threshold rejects everything.
    thr = 16'd20;
    start_search(2);
    run_row(2, {24'd0, 12'd2, 12'd1}, 1'b1, {32'd0, 16'd30, 16'd21}, 1, 1, 0, 0, 4'b0011);
    wait_done(2, edges);
    chk("t3_min_score", {32'd0, min_score2}, {32'd0, 32'hFFFF_FFFF});
    chk("t3_min_id", {40'd0, min_id2}, 64'd0);
    chk("t3_global", {36'd0, gms2, gmi2}, {36'd0, 16'hFFFF, 12'd0});
    thr = 16'hFFFE;

    // Staggered valids, then an all-empty last row.
    start_search(2);
    run_row(2, {24'd0, 12'd4, 12'd3}, 1'b0, {32'd0, 16'd90, 16'd100}, 1, 6, 0, 0, 4'b0011);
    run_row(2, 48'd0, 1'b1, 64'd0, 0, 0, 0, 0, 4'b0000);
    wait_done(2, edges);
    // Empty-row handshake -> UPDATE, 2 REDUCE, DONE.
    chk("latency_empty_last", 64'(edges), 64'd3);
    chk("t4_min_score", {32'd0, min_score2}, {32'd0, 16'd90, 16'd100});
    chk("t4_min_id", {40'd0, min_id2}, {40'd0, 12'd4, 12'd3});
    chk("t4_global", {36'd0, gms2, gmi2}, {36'd0, 16'd90, 12'd4});

    // Four lanes, equal minima on lanes 1 and 3; start during REDUCE ignored.
    start_search(4);
    run_row(4, {12'd4, 12'd3, 12'd2, 12'd1}, 1'b1,
            {16'd12, 16'd15, 16'd12, 16'd20}, 1, 1, 1, 1, 4'b1111);
    @(posedge clk); #1;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_done(4, edges);
    chk("latency_t5_rest", 64'(edges), 64'd3);
    chk("t5_global", {36'd0, gms4, gmi4}, {36'd0, 16'd12, 12'd2});
    chk("t5_min_id", {16'd0, min_id4}, {16'd0, 12'd4, 12'd3, 12'd2, 12'd1});
    chk("t5_idle_after", {63'd0, busy4}, 64'd0);

    // Reset during COLLECT, then a clean search.
    start_search(2);
    run_row(2, {24'd0, 12'd2, 12'd1}, 1'b1, {32'd0, 16'd3, 16'd2}, 1, 0, 0, 0, 4'b0011);
    chk("t6_busy_collect", {63'd0, busy2}, 64'd1);
    reset_N = 1'b0;
    #1;
    chk("t6_rst_busy", {63'd0, busy2}, 64'd0);
    chk("t6_rst_min_score", {32'd0, min_score2}, {32'd0, 32'hFFFF_FFFF});
    chk("t6_rst_global", {36'd0, gms2, gmi2}, {36'd0, 16'hFFFF, 12'd0});
    chk("t6_rst_outs", {61'd0, row_ready2, done2, busy2}, 64'd0);
    @(negedge clk); reset_N = 1'b1;
    @(posedge clk); #1;
    start_search(2);
    run_row(2, {24'd0, 12'd4, 12'd3}, 1'b1, {32'd0, 16'd5, 16'd6}, 3, 1, 0, 0, 4'b0011);
    wait_done(2, edges);
    chk("latency_t6", 64'(edges), 64'd3);
    chk("t6_min_score", {32'd0, min_score2}, {32'd0, 16'd5, 16'd6});
    chk("t6_min_id", {40'd0, min_id2}, {40'd0, 12'd4, 12'd3});
    chk("t6_global", {36'd0, gms2, gmi2}, {36'd0, 16'd5, 12'd4});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
